audio_feed_pio_bidir: RTL and testbench



---
 rtl/audio_feed_pio_bidir.sv | 179 +++++++++++++++++
 tb/tb_audio_feed_pio_bidir.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_feed_pio_bidir.sv
// audio_feed_pio_bidir: WIDTH-bit Avalon-MM GPIO port with per-bit output enable,
// synchronised inputs and atomic set/clear of the output register.
// Optional edge capture + interrupt is built only when PIO_EDGE_IRQ_EN is defined.
module audio_feed_pio_bidir #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] OUT_RESET   = 32'h0,
    parameter logic [31:0] DIR_RESET   = 32'h0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out,
    output logic [WIDTH-1:0] pio_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    // Bits above WIDTH are deliberately ignored.
    assign unused_wdata = ^(writedata >> WIDTH);

    // ---------------------------------------------------------------- outputs
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;

    // Next-state for the output data and direction registers.
    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   out_d = wdata;
                ADDR_DIR:    dir_d = wdata;
                ADDR_OUTSET: out_d = out_q | wdata;
                ADDR_OUTCLR: out_d = out_q & ~wdata;
                default:     ;
            endcase
        end
    end

    // Output data and direction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= OUT_RESET[WIDTH-1:0];
            dir_q <= DIR_RESET[WIDTH-1:0];
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
        end
    end

    assign pio_out = out_q;
    assign pio_oe  = dir_q;

    // ---------------------------------------------------------- input sync
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  pin_sync;

    // Multi-stage synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pio_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign pin_sync = sync_q[SYNC_STAGES-1];

`ifdef PIO_EDGE_IRQ_EN
    // ------------------------------------------------------ edge capture
    localparam logic [2:0]  ADDR_IRQMASK = 3'd2;
    localparam logic [2:0]  ADDR_EDGECAP = 3'd3;
    localparam int unsigned ArmCycles    = SYNC_STAGES + 1;

    logic [2:0]       arm_cnt_q;
    logic             armed;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             irq_q;

    // Edges stay disarmed until the synchroniser has flushed its reset zeros.
    assign armed = (arm_cnt_q == 3'(ArmCycles));

    // Edge selection; nothing is reported while disarmed.
    always_comb begin
        edge_hit = '0;
        if (armed) begin
            if (EDGE_TYPE == 0) begin
                edge_hit = pin_sync & ~prev_q;
            end else if (EDGE_TYPE == 1) begin
                edge_hit = ~pin_sync & prev_q;
            end else begin
                edge_hit = pin_sync ^ prev_q;
            end
        end
    end

    // Mask and capture next-state; a new edge beats a same-cycle clear.
    always_comb begin
        mask_d = mask_q;
        cap_d  = cap_q;
        if (wr_en && address == ADDR_IRQMASK) begin
            mask_d = wdata;
        end
        if (wr_en && address == ADDR_EDGECAP) begin
            cap_d = cap_q & ~wdata;
        end
        cap_d = cap_d | edge_hit;
    end

    // Arming counter, previous-sample, mask, capture and registered irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt_q <= '0;
            prev_q    <= '0;
            mask_q    <= '0;
            cap_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q + 3'd1;
            end
            prev_q <= pin_sync;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            irq_q  <= |(cap_q & mask_q);
        end
    end

    assign irq = irq_q;
`else
    logic unused_cfg;

    assign unused_cfg = (EDGE_TYPE > 2);
    assign irq        = 1'b0;
`endif

    // ------------------------------------------------------------- readback
    logic [WIDTH-1:0] rd_val;

    // Combinational read mux; unlisted addresses read zero.
    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:    rd_val = pin_sync;
            ADDR_DIR:     rd_val = dir_q;
`ifdef PIO_EDGE_IRQ_EN
            ADDR_IRQMASK: rd_val = mask_q;
            ADDR_EDGECAP: rd_val = cap_q;
`endif
            default:      rd_val = '0;
        endcase
    end

    assign readdata = 32'(rd_val);

endmodule

// File: tb/tb_audio_feed_pio_bidir.sv
// Bench for audio_feed_pio_bidir (WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=2).
// A history-based model is compared every cycle; directed steps add literal checks.
module tb_audio_feed_pio_bidir;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  pio_in;
    logic [7:0]  pio_out;
    logic [7:0]  pio_oe;
    logic        irq;

    int checks = 0;
    int errors = 0;

    audio_feed_pio_bidir #(
        .WIDTH      (8),
        .OUT_RESET  (32'hA5),
        .DIR_RESET  (32'h0F),
        .SYNC_STAGES(2),
        .EDGE_TYPE  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .pio_in    (pio_in),
        .pio_out   (pio_out),
        .pio_oe    (pio_oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    // Pin state is derived from a history of sampled inputs rather than stage flops.
    logic [7:0] m_out, m_dir, m_mask, m_cap;
    logic       m_irq;
    logic [7:0] hist[$];
    int         since_rst;
    bit         model_valid = 0;
    logic [7:0] m_sync, m_prev, m_hit, m_wd;
    bit         m_wr;

    function automatic logic [7:0] sync_val();
        return (hist.size() >= S) ? hist[S-1] : 8'h00;
    endfunction

    always @(posedge clk) begin
        model_valid = 1;
        if (reset) begin
            m_out     = 8'hA5;
            m_dir     = 8'h0F;
            m_mask    = 8'h00;
            m_cap     = 8'h00;
            m_irq     = 1'b0;
            since_rst = 0;
            hist.delete();
        end else begin
            m_sync = sync_val();
            m_prev = (hist.size() > S) ? hist[S] : 8'h00;
            m_hit  = (since_rst >= S + 1) ? (m_sync ^ m_prev) : 8'h00;
            m_wr   = chipselect && !write_n;
            m_wd   = writedata[7:0];
`ifdef PIO_EDGE_IRQ_EN
            m_irq = |(m_cap & m_mask);
            if (m_wr && address == 3'd3) m_cap = m_cap & ~m_wd;
            m_cap = m_cap | m_hit;
            if (m_wr && address == 3'd2) m_mask = m_wd;
`endif
            if (m_wr) begin
                case (address)
                    3'd0: m_out = m_wd;
                    3'd1: m_dir = m_wd;
                    3'd4: m_out = m_out | m_wd;
                    3'd5: m_out = m_out & ~m_wd;
                    default: ;
                endcase
            end
            hist.push_front(pio_in);
            if (hist.size() > S + 1) void'(hist.pop_back());
            if (since_rst < 1000) since_rst++;
        end
    end

    logic [31:0] exp_rd;

    always @(negedge clk) begin
        if (model_valid) begin
            case (address)
                3'd0:    exp_rd = {24'h0, sync_val()};
                3'd1:    exp_rd = {24'h0, m_dir};
                3'd2:    exp_rd = {24'h0, m_mask};
                3'd3:    exp_rd = {24'h0, m_cap};
                default: exp_rd = 32'h0;
            endcase
            chk("model pio_out", {24'h0, pio_out}, {24'h0, m_out});
            chk("model pio_oe", {24'h0, pio_oe}, {24'h0, m_dir});
            chk("model irq", {31'h0, irq}, {31'h0, m_irq});
            chk("model readdata", readdata, exp_rd);
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        pio_in     = 8'h00;
        cyc();
        do_reset();

        // Reset values
        chk("reset pio_out", {24'h0, pio_out}, 32'hA5);
        chk("reset pio_oe", {24'h0, pio_oe}, 32'h0F);
        chk("reset irq", {31'h0, irq}, 32'h0);
        rd_chk("reset read irqmask", 3'd2, 32'h0);
        rd_chk("reset read edgecap", 3'd3, 32'h0);
        rd_chk("reset read data", 3'd0, 32'h0);

        // Write, set, clear on successive cycles
        wr(3'd0, 32'h00);
        chk("data write", {24'h0, pio_out}, 32'h00);
        wr(3'd4, 32'h81);
        chk("outset", {24'h0, pio_out}, 32'h81);
        wr(3'd5, 32'h01);
        chk("outclr", {24'h0, pio_out}, 32'h80);
        rd_chk("read outset", 3'd4, 32'h0);
        rd_chk("read outclr", 3'd5, 32'h0);

        // Upper write bits ignored, readback zero-extended
        wr(3'd0, 32'hFFFF_FF5A);
        chk("data wide write", {24'h0, pio_out}, 32'h5A);
        wr(3'd1, 32'h1234_56C3);
        chk("dir write", {24'h0, pio_oe}, 32'hC3);
        rd_chk("dir readback", 3'd1, 32'h0000_00C3);

        // Reserved addresses
        wr(3'd6, 32'hFF);
        wr(3'd7, 32'hFF);
        chk("reserved no effect", {24'h0, pio_out}, 32'h5A);
        rd_chk("reserved read 6", 3'd6, 32'h0);
        rd_chk("reserved read 7", 3'd7, 32'h0);

        // Synchroniser latency: change at cycle N, visible at N+2
        address = 3'd0;
        pio_in  = 8'h3C;
        #1 chk("sync N", readdata, 32'h00);
        cyc();
        chk("sync N+1", readdata, 32'h00);
        cyc();
        chk("sync N+2", readdata, 32'h3C);
        cyc();

        // Pins high through reset release must not capture an edge
        pio_in = 8'hFF;
        do_reset();
        chk("mid reset pio_out", {24'h0, pio_out}, 32'hA5);
        chk("mid reset pio_oe", {24'h0, pio_oe}, 32'h0F);
        for (int i = 0; i < 6; i++) cyc();
        rd_chk("arming edgecap", 3'd3, 32'h0);
        rd_chk("arming data", 3'd0, 32'hFF);

`ifdef PIO_EDGE_IRQ_EN
        pio_in = 8'h00;
        do_reset();
        for (int i = 0; i < 5; i++) cyc();
        wr(3'd2, 32'h04);
        address = 3'd3;
        pio_in  = 8'h04;
        cyc();
        cyc();
        chk("edgecap N+2", readdata, 32'h0);
        cyc();
        chk("edgecap N+3", readdata, 32'h04);
        chk("irq N+3", {31'h0, irq}, 32'h0);
        cyc();
        chk("irq N+4", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h04);
        rd_chk("edgecap cleared", 3'd3, 32'h0);
        cyc();
        chk("irq after clear", {31'h0, irq}, 32'h0);

        // Edge on bit 0 collides with a clear of bit 0
        pio_in = 8'h05;
        cyc();
        cyc();
        wr(3'd3, 32'h01);
        rd_chk("collision set wins", 3'd3, 32'h01);
        wr(3'd2, 32'h01);
        cyc();
        chk("irq after mask", {31'h0, irq}, 32'h1);
        for (int i = 0; i < 3; i++) cyc();
`else
        wr(3'd2, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            pio_in = (i % 2 == 0) ? 8'h00 : 8'hFF;
            cyc();
            chk("macro off irq", {31'h0, irq}, 32'h0);
        end
        for (int i = 0; i < 3; i++) cyc();
        rd_chk("macro off edgecap", 3'd3, 32'h0);
        rd_chk("macro off irqmask", 3'd2, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
